// File: rtl/mem_bus_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_bus_responder: wait-stated data memory for the load/store port   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module mem_bus_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_be,
    output logic        o_ready,
    output logic        o_rvalid,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic [31:0] o_wrAddr,
    output logic [31:0] o_wrData
);

    localparam int          c_AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] c_LIMIT     = 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  c_WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic [1:0]  c_ST_IDLE   = 2'd0;
    localparam logic [1:0]  c_ST_WAIT   = 2'd1;
    localparam logic [1:0]  c_ST_RESP   = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_ready;
    logic        r_rvalid;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [31:0] r_wr_addr;
    logic [31:0] r_wr_data;
    logic        r_we;
    logic        r_req_err;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic            w_accept;
    logic            w_in_err;
    logic [c_AW-1:0] w_in_idx;
    logic [c_AW-1:0] w_resp_idx;
    logic            w_enter_resp;
    logic            w_src_we;
    logic            w_src_err;
    logic [c_AW-1:0] w_src_idx;
    logic            w_commit;
    logic [31:0]     w_merged;

    assign w_accept   = (r_state == c_ST_IDLE) && r_ready && i_req;
    assign w_in_err   = (i_addr[1:0] != 2'b00) || ({1'b0, i_addr} >= c_LIMIT);
    assign w_in_idx   = i_addr[c_AW+1:2];
    assign w_resp_idx = r_addr[c_AW+1:2];

    // With zero wait states RESP is entered on the accept edge, before the
    // latched copies exist, so the response is built from the live inputs.
    assign w_enter_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                          ((r_state == c_ST_WAIT) && (r_cnt <= 4'd1));
    assign w_src_we     = w_accept ? i_we     : r_we;
    assign w_src_err    = w_accept ? w_in_err : r_req_err;
    assign w_src_idx    = w_accept ? w_in_idx : w_resp_idx;

    assign w_commit = (r_state == c_ST_RESP) && r_we && !r_req_err && (r_be != 4'h0);

    always_comb begin
        w_merged = r_mem[w_resp_idx];
        for (int k = 0; k < 4; k++) begin
            if (r_be[k]) begin
                w_merged[8*k +: 8] = r_wdata[8*k +: 8];
            end
        end
    end

    // Array is deliberately left out of reset; a reset in RESP drops the write.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_commit) begin
            r_mem[w_resp_idx] <= w_merged;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= 4'd0;
            r_ready   <= 1'b0;
            r_rvalid  <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= 32'h0;
            r_wr_addr <= 32'h0;
            r_wr_data <= 32'h0;
            r_we      <= 1'b0;
            r_req_err <= 1'b0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_be      <= 4'h0;
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= 32'h0;
            if (w_enter_resp) begin
                r_rvalid <= 1'b1;
                r_err    <= w_src_err;
                r_rdata  <= (!w_src_we && !w_src_err) ? r_mem[w_src_idx] : 32'h0;
            end
            case (r_state)
                c_ST_IDLE: begin
                    // ready rises one edge after reset is released
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_ready   <= 1'b0;
                        r_we      <= i_we;
                        r_req_err <= w_in_err;
                        r_addr    <= i_addr;
                        r_wdata   <= i_wdata;
                        r_be      <= i_be;
                        r_cnt     <= c_WAIT_LOAD;
                        r_state   <= (WAIT_CYCLES == 0) ? c_ST_RESP : c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (r_cnt <= 4'd1) begin
                        r_state <= c_ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                    r_ready <= 1'b1;
                    if (w_commit) begin
                        r_wr_addr <= r_addr;
                        r_wr_data <= w_merged;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready  = r_ready;
    assign o_rvalid = r_rvalid;
    assign o_rdata  = r_rdata;
    assign o_err    = r_err;
    assign o_wrAddr = r_wr_addr;
    assign o_wrData = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_mem_bus_responder: scoreboard bench for mem_bus_responder         |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_mem_bus_responder;

    localparam int DEPTH = 256;
    localparam int W     = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        ready, rvalid, err;
    logic [31:0] rdata, wr_addr, wr_data;

    logic        req0, we0;
    logic [31:0] addr0, wdata0;
    logic [3:0]  be0;
    logic        ready0, rvalid0, err0;
    logic [31:0] rdata0, wr_addr0, wr_data0;

    mem_bus_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) u_dut (
        .i_clk(clk), .i_reset(reset), .i_req(req), .i_we(we), .i_addr(addr),
        .i_wdata(wdata), .i_be(be), .o_ready(ready), .o_rvalid(rvalid),
        .o_rdata(rdata), .o_err(err), .o_wrAddr(wr_addr), .o_wrData(wr_data)
    );

    mem_bus_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .i_clk(clk), .i_reset(reset), .i_req(req0), .i_we(we0), .i_addr(addr0),
        .i_wdata(wdata0), .i_be(be0), .o_ready(ready0), .o_rvalid(rvalid0),
        .o_rdata(rdata0), .o_err(err0), .o_wrAddr(wr_addr0), .o_wrData(wr_data0)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        chk_rdata;
        logic        err;
        logic [31:0] wa;
        logic [31:0] wd;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mdl [DEPTH];
    logic [31:0] m_wa = 32'h0;
    logic [31:0] m_wd = 32'h0;
    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, want, cyc);
        end
    endfunction

    // Reference: byte-lane merge into a word array, applied at issue time
    // since each transaction completes before the next is accepted.
    function automatic void model_push(input logic w, input logic [31:0] a, input logic [31:0] d,
                                       input logic [3:0] b, input int due);
        exp_t e;
        int   idx;
        e.err       = (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
        e.chk_rdata = e.err || !w;
        e.rdata     = 32'h0;
        if (!e.err) begin
            idx = int'(a[31:2]);
            if (w) begin
                if (b != 4'h0) begin
                    for (int k = 0; k < 4; k++)
                        if (b[k]) mdl[idx][8*k +: 8] = d[8*k +: 8];
                    m_wa = a;
                    m_wd = mdl[idx];
                end
            end else begin
                e.rdata = mdl[idx];
            end
        end
        e.wa  = m_wa;
        e.wd  = m_wd;
        e.due = due;
        sbq.push_back(e);
    endfunction

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input bit track);
        int n = 0;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        while (ready !== 1'b1) begin
            if (n > 40) begin
                check("ready_timeout", {31'h0, ready}, 32'h1);
                req = 1'b0;
                return;
            end
            n++;
            @(negedge clk);
        end
        if (track) model_push(w, a, d, b, cyc + 1 + W);
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    // Monitor: every response strobe is matched against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rvalid === 1'b1) begin
                if (sbq.size() == 0) begin
                    check("unexpected_rvalid", {31'h0, rvalid}, 32'h0);
                end else begin
                    e = sbq.pop_front();
                    check("latency", 32'(cyc), 32'(e.due));
                    check("err", {31'h0, err}, {31'h0, e.err});
                    if (e.chk_rdata) check("rdata", rdata, e.rdata);
                    @(negedge clk);
                    check("rvalid_pulse", {31'h0, rvalid}, 32'h0);
                    check("wr_addr", wr_addr, e.wa);
                    check("wr_data", wr_data, e.wd);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [31:0] a, d, d0;
        int          r, n;

        reset = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h0; wdata = 32'h1234_5678; be = 4'hF;
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0; be0 = 4'h0;

        // reset held with a pending request
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_ready", {31'h0, ready}, 32'h0);
            check("rst_rvalid", {31'h0, rvalid}, 32'h0);
            check("rst_err", {31'h0, err}, 32'h0);
            check("rst_rdata", rdata, 32'h0);
            check("rst_wr_addr", wr_addr, 32'h0);
            check("rst_wr_data", wr_data, 32'h0);
        end
        reset = 1'b0; req = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'h0, ready}, 32'h1);

        // directed sequence on word 0x10
        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
        issue(1'b1, 32'h10, 32'h1122_3344, 4'h5, 1'b1);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
        issue(1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 1'b1);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
        issue(1'b0, 32'h12, 32'h0, 4'h0, 1'b1);
        issue(1'b1, 32'(4 * DEPTH), 32'hA5A5_A5A5, 4'hF, 1'b1);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
        // fixed expectation for the byte-lane merge, independent of the model
        check("be_merge_model", mdl[4], 32'hDE22_BE44);

        for (int i = 0; i < 32; i++) issue(1'b1, 32'(i * 4), $urandom, 4'hF, 1'b1);

        // reset one cycle after accepting a write: no response, no commit
        issue(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("abort_rvalid", {31'h0, rvalid}, 32'h0);
            check("abort_ready", {31'h0, ready}, 32'h0);
            check("abort_wr_addr", wr_addr, 32'h0);
        end
        reset = 1'b0;
        m_wa = 32'h0;
        m_wd = 32'h0;
        issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b1);

        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 7);
            if (r == 0)      a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
            else if (r == 1) a = 32'(4 * DEPTH) + (32'($urandom_range(0, 1000)) << 2);
            else             a = 32'($urandom_range(0, 31)) << 2;
            d = $urandom;
            issue(1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)), 1'b1);
        end

        // zero-wait-state instance: requests held high back to back
        d0 = $urandom;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wdata0 = d0; be0 = 4'hF;
        for (int i = 0; i < 6; i++) begin
            check("w0_ready", {31'h0, ready0}, (i % 2 == 0) ? 32'h1 : 32'h0);
            check("w0_rvalid", {31'h0, rvalid0}, (i % 2 == 1) ? 32'h1 : 32'h0);
            @(negedge clk);
        end
        we0 = 1'b0;
        @(negedge clk);
        req0 = 1'b0;
        check("w0_read_rvalid", {31'h0, rvalid0}, 32'h1);
        check("w0_read_err", {31'h0, err0}, 32'h0);
        check("w0_read_rdata", rdata0, d0);
        check("w0_wr_addr", wr_addr0, 32'h40);
        check("w0_wr_data", wr_data0, d0);

        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) check("drain", 32'(sbq.size()), 32'h0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
